hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 16-bit MIPS core.
- Drives write-enable and flush for the PC and for the IF/ID pipeline register, plus bubble insertion into ID/EX.
- Handles load-use stalls, taken-branch flushes, instruction-memory wait states with a watchdog, and HALT/resume.
- Sits beside IF_ID and is fed by decode (ID), execute (EX) and the instruction-memory port.

Parameters:
- REG_AW, 3: register-index width (8 registers; R0 is hardwired zero).
- FLUSH_CYCLES, 1: cycles of IF/ID flush after a taken branch; must be at least 1.
- MEM_TIMEOUT, 255: maximum consecutive WAIT_MEM cycles before fault; 0 disables the watchdog.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_AW  source register A of the instruction in ID.
- id_rt  in  REG_AW  source register B of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_halt  in  1  ID instruction is HALT.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  destination register of the EX instruction.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- resume  in  1  single-cycle pulse; leaves HALT.
- pc_we  out  1  PC update enable.
- if_id_we  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP (0x0000) instead of the fetched word.
- id_ex_bubble  out  1  ID/EX loads NOP control.
- halted  out  1  FSM is in HALT.
- imem_timeout  out  1  sticky watchdog fault.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0 outside HALT.
- flush_events  out  CNT_W  saturating count of accepted taken branches.

Behaviour:
- Reset (rst=1):
  - Next state RUN; flush counter, wait counter, stall_cycles, flush_events and imem_timeout cleared; halted=0.
  - While rst is high: pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1.
- Hazard term: lu = ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Outputs are combinational from state and inputs (zero latency). State and counters are registered.
- FSM states: RUN, FLUSH, WAIT_MEM, HALT. Priority within any state: rst > ex_branch_taken > id_is_halt > !imem_ready > lu.
- RUN:
  - branch: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1; flush_events++.
    - FLUSH_CYCLES>1: go FLUSH, fcnt=FLUSH_CYCLES-1.
    - Otherwise stay RUN.
  - halt: pc_we=0, if_id_we=0, id_ex_bubble=1; go HALT.
  - !imem_ready: pc_we=0, if_id_we=1, if_id_flush=1, id_ex_bubble=0; go WAIT_MEM with wcnt=1.
  - lu: pc_we=0, if_id_we=0, id_ex_bubble=1; stay RUN (exactly one bubble per load).
  - Otherwise: pc_we=1, if_id_we=1, if_id_flush=0, id_ex_bubble=0.
- FLUSH:
  - Outputs pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1.
  - fcnt-- each cycle; at fcnt==1, go RUN.
  - A branch here reloads fcnt=FLUSH_CYCLES-1 and counts an event.
- WAIT_MEM:
  - Outputs as in the RUN !imem_ready case; wcnt++ each cycle.
  - imem_ready=1: that cycle uses the RUN rules (including lu) and returns to RUN.
  - A branch here: pc_we=1 (redirect), flush outputs, go FLUSH/RUN as in RUN; the stale fetch is dropped.
  - MEM_TIMEOUT!=0 and wcnt==MEM_TIMEOUT with imem_ready still 0: set imem_timeout, go HALT.
- HALT:
  - halted=1; pc_we=0, if_id_we=0, id_ex_bubble=1; branch input ignored.
  - resume=1: go RUN next cycle.
  - imem_timeout is cleared only by rst.
- Counters:
  - stall_cycles increments on each cycle with pc_we=0 outside HALT and not in reset.
  - Both counters saturate at all-ones (no wrap).

Decomposition:
- Package hazard_pkg holds:
  - the state enum (RUN=2'd0, FLUSH=2'd1, WAIT_MEM=2'd2, HALT=2'd3);
  - the NOP_INSTR=16'h0000 constant;
  - REG_AW.
- One natural sub-module: sat_counter (width parameter, synchronous clear, increment enable), instantiated twice.

Test Plan:
- Reset held 3 cycles, then released with imem_ready=1 and no hazards -> during reset flush=1/bubble=1, counters 0; after release pc_we=1, if_id_we=1 every cycle.
- LW R3 in EX (ex_rd=3, ex_mem_read=1) with ID id_rs=3, id_uses_rs=1 -> exactly one cycle pc_we=0, if_id_we=0, bubble=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- FLUSH_CYCLES=2, ex_branch_taken pulse in RUN -> 2 consecutive cycles with if_id_flush=1, pc_we=1; flush_events=1; back to RUN.
- imem_ready low for 4 cycles -> pc_we=0 and if_id_flush=1 for 4 cycles, stall_cycles=4. Add a branch on cycle 2 -> pc_we=1 on that cycle, then FLUSH.
- MEM_TIMEOUT=8, imem_ready held low -> imem_timeout=1 and halted=1 after 8 cycles. resume -> RUN, imem_timeout stays 1 until rst.
- id_is_halt with simultaneous ex_branch_taken -> branch wins (flush, no HALT). id_is_halt alone -> halted=1 until a resume pulse.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline sequencing controller.
//   REG_AW    - register-index width (8 registers, R0 hardwired to zero)
//   NOP_INSTR - encoding loaded into IF/ID on a flush
//   state_e   - controller FSM states
package hazard_pkg;

    localparam int unsigned REG_AW = 3;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush   = 2'd1,
        StWaitMem = 2'd2,
        StHalt    = 2'd3
    } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline datapath and the hazard controller.
//   Pipeline -> controller: ID source regs/uses/halt, EX load/dest/branch, imem_ready, resume.
//   Controller -> pipeline: pc_we, if_id_we, if_id_flush, id_ex_bubble, halted,
//                           imem_timeout and the two performance counters.
//   master modport: pipeline side; slave modport: controller side.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_is_halt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_branch_taken;
    logic              imem_ready;
    logic              resume;

    logic              pc_we;
    logic              if_id_we;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              halted;
    logic              imem_timeout;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_halt,
        output ex_mem_read, ex_rd, ex_branch_taken, imem_ready, resume,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, halted, imem_timeout,
        input  stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_halt,
        input  ex_mem_read, ex_rd, ex_branch_taken, imem_ready, resume,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, halted, imem_timeout,
        output stall_cycles, flush_events
    );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk_i   - clock
//   clr_i   - synchronous clear (has priority over en_i)
//   en_i    - increment enable
//   count_o - current count
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 16-bit MIPS core.
//   clk - core clock
//   rst - synchronous active-high reset
//   bus - hazard_ctrl_if slave: hazard inputs from ID/EX/imem, PC and pipeline-register
//         controls out, HALT status, sticky imem watchdog fault, stall/flush counters.
// Outputs are combinational from state and inputs; state and counters are registered.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);

    localparam int unsigned FcntW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
    localparam int unsigned WcntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [FcntW-1:0] FcntReload = FcntW'(FLUSH_CYCLES - 1);
    localparam logic [WcntW-1:0] WcntLimit  = WcntW'(MEM_TIMEOUT);
    localparam bit MultiFlush    = (FLUSH_CYCLES > 1);
    localparam bit WatchdogOn    = (MEM_TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [FcntW-1:0] fcnt_q, fcnt_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic             timeout_q, timeout_d;

    logic pc_we, if_id_we, if_id_flush, id_ex_bubble;
    logic branch_acc;
    logic lu;

    // Load-use: the loaded value is not available to the ID instruction until one cycle later.
    assign lu = bus.ex_mem_read && (bus.ex_rd != '0) &&
                ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                 (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        wcnt_d       = wcnt_q;
        timeout_d    = timeout_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        branch_acc   = 1'b0;

        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                // WAIT_MEM shares the RUN priority chain; only the !imem_ready leg differs.
                StRun, StWaitMem: begin
                    if (bus.ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        branch_acc   = 1'b1;
                        state_d      = StRun;
                        if (MultiFlush) begin
                            state_d = StFlush;
                            fcnt_d  = FcntReload;
                        end
                    end else if (bus.id_is_halt) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = StHalt;
                    end else if (!bus.imem_ready) begin
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                        if (state_q == StRun) begin
                            state_d = StWaitMem;
                            wcnt_d  = WcntW'(1);
                        end else if (WatchdogOn && (wcnt_q == WcntLimit)) begin
                            timeout_d = 1'b1;
                            state_d   = StHalt;
                        end else begin
                            wcnt_d = wcnt_q + WcntW'(1);
                        end
                    end else begin
                        if (lu) begin
                            pc_we        = 1'b0;
                            if_id_we     = 1'b0;
                            id_ex_bubble = 1'b1;
                        end
                        state_d = StRun;
                    end
                end
                StFlush: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (bus.ex_branch_taken) begin
                        branch_acc = 1'b1;
                        fcnt_d     = FcntReload;
                    end else if (fcnt_q <= FcntW'(1)) begin
                        state_d = StRun;
                    end else begin
                        fcnt_d = fcnt_q - FcntW'(1);
                    end
                end
                StHalt: begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (bus.resume) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            fcnt_q    <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .clr_i   (rst),
        .en_i    (!rst && !pc_we && (state_q != StHalt)),
        .count_o (bus.stall_cycles)
    );

    sat_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk),
        .clr_i   (rst),
        .en_i    (branch_acc),
        .count_o (bus.flush_events)
    );

    assign bus.pc_we        = pc_we;
    assign bus.if_id_we     = if_id_we;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.halted       = (state_q == StHalt) && !rst;
    assign bus.imem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with FLUSH_CYCLES=2, MEM_TIMEOUT=8.
// Inputs change 1ns after each rising edge; outputs are sampled 1ns later.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    hazard_ctrl_if #(.CNT_W(16)) bus ();

    hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (8),
        .CNT_W        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs           = '0;
        bus.id_rt           = '0;
        bus.id_uses_rs      = 1'b0;
        bus.id_uses_rt      = 1'b0;
        bus.id_is_halt      = 1'b0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_rd           = '0;
        bus.ex_branch_taken = 1'b0;
        bus.imem_ready      = 1'b1;
        bus.resume          = 1'b0;
    endtask

    // Waits 1ns for combinational settle, then checks the four pipeline controls.
    task automatic chk_ctl(input string tag, input logic pc, input logic we, input logic fl,
                           input logic bub, input bit chk_fl);
        #1;
        check({tag, ".pc_we"}, {31'd0, bus.pc_we}, {31'd0, pc});
        check({tag, ".if_id_we"}, {31'd0, bus.if_id_we}, {31'd0, we});
        if (chk_fl) check({tag, ".if_id_flush"}, {31'd0, bus.if_id_flush}, {31'd0, fl});
        check({tag, ".id_ex_bubble"}, {31'd0, bus.id_ex_bubble}, {31'd0, bub});
    endtask

    task automatic chk_cnt(input string tag, input int unsigned stall, input int unsigned ev);
        check({tag, ".stall_cycles"}, {16'd0, bus.stall_cycles}, stall);
        check({tag, ".flush_events"}, {16'd0, bus.flush_events}, ev);
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        check(tag, {31'd0, got}, {31'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        idle();

        // Reset held 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            chk_bit("rst.halted", bus.halted, 1'b0);
            chk_bit("rst.timeout", bus.imem_timeout, 1'b0);
            chk_cnt("rst", 0, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            chk_ctl("run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        chk_cnt("run", 0, 0);

        // Load-use on rs.
        bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd3; bus.id_rs = 3'd3; bus.id_uses_rs = 1'b1;
        chk_ctl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        chk_ctl("lu_rs_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt("lu_rs", 1, 0);
        tick();

        // Load into R0 never stalls.
        bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd0; bus.id_rs = 3'd0; bus.id_uses_rs = 1'b1;
        chk_ctl("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        chk_cnt("lu_r0", 1, 0);

        // Load-use on rt, then the same match with id_uses_rt clear.
        bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd5; bus.id_rs = 3'd2; bus.id_uses_rs = 1'b1;
        bus.id_rt = 3'd5; bus.id_uses_rt = 1'b1;
        chk_ctl("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        bus.id_uses_rt = 1'b0;
        chk_ctl("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        chk_cnt("lu_rt", 2, 0);

        // Taken branch in RUN: two flush cycles.
        bus.ex_branch_taken = 1'b1;
        chk_ctl("br0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        bus.ex_branch_taken = 1'b0;
        chk_ctl("br1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_cnt("br", 2, 1);
        tick();
        chk_ctl("br_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Instruction memory stalls 4 cycles.
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_ctl("wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        bus.imem_ready = 1'b1;
        chk_ctl("wait_ready", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt("wait", 6, 1);
        tick();
        chk_ctl("wait_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Branch on the second wait cycle redirects and flushes.
        bus.imem_ready = 1'b0;
        chk_ctl("wbr0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        bus.ex_branch_taken = 1'b1;
        chk_ctl("wbr1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        bus.ex_branch_taken = 1'b0; bus.imem_ready = 1'b1;
        chk_ctl("wbr_flush", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk_ctl("wbr_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt("wbr", 7, 2);

        // HALT together with a branch: branch wins.
        bus.id_is_halt = 1'b1; bus.ex_branch_taken = 1'b1;
        chk_ctl("hbr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        chk_bit("hbr.halted", bus.halted, 1'b0);
        chk_ctl("hbr_flush", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk_ctl("hbr_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt("hbr", 7, 3);

        // HALT alone; branches ignored while halted.
        bus.id_is_halt = 1'b1;
        chk_ctl("halt_enter", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_bit("halt_enter.halted", bus.halted, 1'b0);
        tick();
        bus.ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk_bit("halt.halted", bus.halted, 1'b1);
            tick();
        end
        chk_cnt("halt", 8, 3);
        bus.ex_branch_taken = 1'b0; bus.resume = 1'b1;
        chk_ctl("halt_resume", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        chk_ctl("halt_left", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_bit("halt_left.halted", bus.halted, 1'b0);
        chk_cnt("halt_left", 8, 3);

        // Watchdog: one RUN cycle then 8 WAIT_MEM cycles before the fault.
        bus.imem_ready = 1'b0;
        chk_ctl("wd_run", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_ctl("wd_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            chk_bit("wd_wait.halted", bus.halted, 1'b0);
            chk_bit("wd_wait.timeout", bus.imem_timeout, 1'b0);
            tick();
        end
        chk_bit("wd.halted", bus.halted, 1'b1);
        chk_bit("wd.timeout", bus.imem_timeout, 1'b1);
        chk_cnt("wd", 17, 3);
        chk_ctl("wd_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.imem_ready = 1'b1; bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        chk_ctl("wd_resumed", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_bit("wd_resumed.halted", bus.halted, 1'b0);
        chk_bit("wd_resumed.timeout", bus.imem_timeout, 1'b1);
        tick();
        chk_bit("wd_sticky.timeout", bus.imem_timeout, 1'b1);

        // Only reset clears the fault and the counters.
        rst = 1'b1;
        chk_ctl("rst2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        chk_bit("rst2.timeout", bus.imem_timeout, 1'b0);
        chk_bit("rst2.halted", bus.halted, 1'b0);
        chk_cnt("rst2", 0, 0);
        chk_ctl("rst2_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
